// File: rtl/uart_tx_if.sv
// Byte hand-off into the UART transmitter: upstream drives valid/data, the transmitter answers with ready.
// Ready is registered; a byte presented while ready is low is simply not taken.
interface uart_tx_if #(
   parameter int DATA_BITS = 8
);
   logic                 i_data_valid;
   logic [DATA_BITS-1:0] i_data;
   logic                 o_ready;

   modport master (
      output i_data_valid,
      output i_data,
      input  o_ready
   );

   modport slave (
      input  i_data_valid,
      input  i_data,
      output o_ready
   );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS LSB first, optional parity, STOP_BITS stop bits; o_tx falls one edge after acceptance.
// Holds ready low for the whole frame, so upstream stalls; valid seen while busy is dropped.
module uart_tx #(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD_RATE = 115200,
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1,
   parameter int PARITY    = 0
) (
   input  logic     clk,
   input  logic     n_rst,
   uart_tx_if.slave bus,
   output logic     o_tx,
   output logic     o_busy
);

   // Integer form of rounding CLK_FREQ/BAUD_RATE to the nearest whole cycle count.
   localparam int CLKS_PER_BIT = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
   localparam bit HAS_PARITY   = (PARITY == 1) || (PARITY == 2);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

   typedef enum logic [4:0] {
      S_IDLE   = 5'b00001,
      S_START  = 5'b00010,
      S_DATA   = 5'b00100,
      S_PARITY = 5'b01000,
      S_STOP   = 5'b10000
   } state_t;

   state_t               r_state;
   logic [CNT_W-1:0]     r_baud_cnt;
   logic [3:0]           r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_parity;
   logic                 r_tx;
   logic                 r_ready;

   logic w_accept;
   logic w_bit_end;
   logic w_par_calc;

   assign w_accept   = bus.i_data_valid && r_ready;
   assign w_bit_end  = (r_baud_cnt == CNT_LAST);
   assign w_par_calc = (PARITY == 1) ? ~^bus.i_data : ^bus.i_data;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state    <= S_IDLE;
         r_baud_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_parity   <= 1'b0;
         r_tx       <= 1'b1;
         r_ready    <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_baud_cnt <= '0;
               r_bit_cnt  <= '0;
               r_tx       <= 1'b1;
               r_ready    <= 1'b1;
               if (w_accept) begin
                  r_shift  <= bus.i_data;
                  r_parity <= w_par_calc;
                  r_tx     <= 1'b0;
                  r_ready  <= 1'b0;
                  r_state  <= S_START;
               end
            end

            S_START: begin
               if (w_bit_end) begin
                  r_baud_cnt <= '0;
                  r_bit_cnt  <= '0;
                  r_tx       <= r_shift[0];
                  r_state    <= S_DATA;
               end else begin
                  r_baud_cnt <= r_baud_cnt + 1'b1;
               end
            end

            // o_tx is loaded with the next line level on the same edge the state advances.
            S_DATA: begin
               if (w_bit_end) begin
                  r_baud_cnt <= '0;
                  if (r_bit_cnt == DATA_LAST) begin
                     r_bit_cnt <= '0;
                     if (HAS_PARITY) begin
                        r_tx    <= r_parity;
                        r_state <= S_PARITY;
                     end else begin
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                     end
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                     r_shift   <= r_shift >> 1;
                     r_tx      <= r_shift[1];
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + 1'b1;
               end
            end

            S_PARITY: begin
               if (w_bit_end) begin
                  r_baud_cnt <= '0;
                  r_bit_cnt  <= '0;
                  r_tx       <= 1'b1;
                  r_state    <= S_STOP;
               end else begin
                  r_baud_cnt <= r_baud_cnt + 1'b1;
               end
            end

            S_STOP: begin
               r_tx <= 1'b1;
               if (w_bit_end) begin
                  r_baud_cnt <= '0;
                  if (r_bit_cnt == STOP_LAST) begin
                     r_bit_cnt <= '0;
                     r_ready   <= 1'b1;
                     r_state   <= S_IDLE;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + 1'b1;
               end
            end

            default: begin
               r_baud_cnt <= '0;
               r_bit_cnt  <= '0;
               r_tx       <= 1'b1;
               r_ready    <= 1'b1;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.o_ready = r_ready;
   assign o_tx        = r_tx;
   assign o_busy      = ~r_ready;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (8N1, 8E2, 8O1 at 434 clk/bit, and a fast 8-bit link with parity code 3).
// Expected frames are queued when a byte is offered and checked cycle by cycle when the line drops.
module tb_uart_tx;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       rst_n  [4];
   logic       vld_d  [4];
   logic [7:0] dat_d  [4];
   logic       tx_w   [4];
   logic       busy_w [4];
   logic       rdy_w  [4];

   uart_tx_if #(.DATA_BITS(8)) bus0 ();
   uart_tx_if #(.DATA_BITS(8)) bus1 ();
   uart_tx_if #(.DATA_BITS(8)) bus2 ();
   uart_tx_if #(.DATA_BITS(8)) bus3 ();

   assign bus0.i_data_valid = vld_d[0];
   assign bus0.i_data       = dat_d[0];
   assign bus1.i_data_valid = vld_d[1];
   assign bus1.i_data       = dat_d[1];
   assign bus2.i_data_valid = vld_d[2];
   assign bus2.i_data       = dat_d[2];
   assign bus3.i_data_valid = vld_d[3];
   assign bus3.i_data       = dat_d[3];
   assign rdy_w[0] = bus0.o_ready;
   assign rdy_w[1] = bus1.o_ready;
   assign rdy_w[2] = bus2.o_ready;
   assign rdy_w[3] = bus3.o_ready;

   uart_tx #(.CLK_FREQ(50000000), .BAUD_RATE(115200), .DATA_BITS(8), .STOP_BITS(1), .PARITY(0))
      u0 (.clk(clk), .n_rst(rst_n[0]), .bus(bus0), .o_tx(tx_w[0]), .o_busy(busy_w[0]));
   uart_tx #(.CLK_FREQ(50000000), .BAUD_RATE(115200), .DATA_BITS(8), .STOP_BITS(2), .PARITY(2))
      u1 (.clk(clk), .n_rst(rst_n[1]), .bus(bus1), .o_tx(tx_w[1]), .o_busy(busy_w[1]));
   uart_tx #(.CLK_FREQ(50000000), .BAUD_RATE(115200), .DATA_BITS(8), .STOP_BITS(1), .PARITY(1))
      u2 (.clk(clk), .n_rst(rst_n[2]), .bus(bus2), .o_tx(tx_w[2]), .o_busy(busy_w[2]));
   uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(222222), .DATA_BITS(8), .STOP_BITS(1), .PARITY(3))
      u3 (.clk(clk), .n_rst(rst_n[3]), .bus(bus3), .o_tx(tx_w[3]), .o_busy(busy_w[3]));

   // bits[k] is the k-th bit on the line; len is the number of bit periods.
   typedef struct packed {
      logic [3:0]  len;
      logic [12:0] bits;
   } exp_t;

   typedef struct {
      int         id;
      logic [7:0] data;
      exp_t       e;
   } vec_t;

   int n_cmp  = 0;
   int n_fail = 0;
   int frames_seen [4];
   int last_start  [4];
   int prev_start  [4];

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];
   exp_t q3[$];

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   function automatic exp_t mk(input int len, input logic [12:0] bits);
      exp_t r;
      r.len  = 4'(len);
      r.bits = bits;
      return r;
   endfunction

   function automatic vec_t mkv(input int id, input logic [7:0] d, input int len, input logic [12:0] bits);
      vec_t v;
      v.id   = id;
      v.data = d;
      v.e    = mk(len, bits);
      return v;
   endfunction

   function automatic int cpb_of(input int id);
      return (id == 3) ? 5 : 434;
   endfunction

   function automatic void sb_push(input int id, input exp_t e);
      case (id)
         0: q0.push_back(e);
         1: q1.push_back(e);
         2: q2.push_back(e);
         default: q3.push_back(e);
      endcase
   endfunction

   function automatic int sb_size(input int id);
      case (id)
         0: return q0.size();
         1: return q1.size();
         2: return q2.size();
         default: return q3.size();
      endcase
   endfunction

   function automatic exp_t sb_pop(input int id);
      case (id)
         0: return q0.pop_front();
         1: return q1.pop_front();
         2: return q2.pop_front();
         default: return q3.pop_front();
      endcase
   endfunction

   task automatic monitor(input int id);
      exp_t e;
      int   cpb;
      int   bad_c;
      logic a_bit, x_bit, hs_ok, aborted;
      cpb = cpb_of(id);
      forever begin
         @(negedge clk);
         if (rst_n[id] === 1'b1 && tx_w[id] === 1'b0) begin
            prev_start[id] = last_start[id];
            last_start[id] = cyc;
            frames_seen[id]++;
            check($sformatf("frame_expected[%0d]", id), 32'(sb_size(id) > 0), 32'd1);
            if (sb_size(id) > 0) e = sb_pop(id);
            else e = mk(10, 13'h1fff);
            bad_c   = -1;
            a_bit   = 1'b0;
            x_bit   = 1'b0;
            hs_ok   = 1'b1;
            aborted = 1'b0;
            for (int c = 0; c < int'(e.len) * cpb; c++) begin
               if (c != 0) @(negedge clk);
               if (rst_n[id] !== 1'b1) begin
                  aborted = 1'b1;
                  break;
               end
               if (bad_c < 0) begin
                  a_bit = tx_w[id];
                  x_bit = e.bits[4'(c / cpb)];
                  if (a_bit !== x_bit) bad_c = c;
               end
               if (rdy_w[id] !== 1'b0 || busy_w[id] !== 1'b1) hs_ok = 1'b0;
            end
            if (!aborted) begin
               check($sformatf("frame[%0d] line bit (first bad cycle %0d)", id, bad_c), 32'(a_bit), 32'(x_bit));
               check($sformatf("frame[%0d] ready low / busy high throughout", id), 32'(hs_ok), 32'd1);
               @(negedge clk);
               if (rst_n[id] === 1'b1)
                  check($sformatf("after_stop[%0d] {tx,ready,busy}", id),
                        32'({tx_w[id], rdy_w[id], busy_w[id]}), 32'b110);
            end
         end
      end
   endtask

   // Called just after a falling edge; returns one falling edge after the accepting rising edge.
   task automatic send(input int id, input logic [7:0] d, input exp_t e);
      int t = 0;
      vld_d[id] = 1'b1;
      dat_d[id] = d;
      while (rdy_w[id] !== 1'b1 && t < 30000) begin
         @(negedge clk);
         t++;
      end
      check($sformatf("send_ready[%0d] 0x%0h", id, d), 32'(rdy_w[id]), 32'd1);
      if (rdy_w[id] === 1'b1) sb_push(id, e);
      @(negedge clk);
   endtask

   task automatic wait_idle(input int id);
      int t = 0;
      while (rdy_w[id] !== 1'b1 && t < 30000) begin
         @(negedge clk);
         t++;
      end
      check($sformatf("idle_reached[%0d]", id), 32'(rdy_w[id]), 32'd1);
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) fork
         automatic int k = i;
         monitor(k);
      join_none
   end

   initial begin
      #(64'd20 * 64'd95000);
      $display("FAIL watchdog: cycles got %0d, want < 95000", cyc);
      n_fail++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs [6];
      int   seen0;
      vecs[0] = mkv(0, 8'hA5, 10, 13'({1'b1, 8'hA5, 1'b0}));
      vecs[1] = mkv(1, 8'hA5, 12, 13'({2'b11, 1'b0, 8'hA5, 1'b0}));
      vecs[2] = mkv(1, 8'h01, 12, 13'({2'b11, 1'b1, 8'h01, 1'b0}));
      vecs[3] = mkv(2, 8'hA5, 11, 13'({1'b1, 1'b1, 8'hA5, 1'b0}));
      vecs[4] = mkv(2, 8'h07, 11, 13'({1'b1, 1'b0, 8'h07, 1'b0}));
      vecs[5] = mkv(0, 8'h3C, 10, 13'({1'b1, 8'h3C, 1'b0}));

      for (int i = 0; i < 4; i++) begin
         vld_d[i]       = 1'b0;
         dat_d[i]       = 8'h00;
         rst_n[i]       = 1'b1;
         frames_seen[i] = 0;
         last_start[i]  = 0;
         prev_start[i]  = 0;
      end
      #2;
      for (int i = 0; i < 4; i++) rst_n[i] = 1'b0;
      #5;
      for (int i = 0; i < 4; i++)
         check($sformatf("reset_outputs[%0d] {tx,ready,busy}", i),
               32'({tx_w[i], rdy_w[i], busy_w[i]}), 32'b110);
      @(negedge clk);
      @(negedge clk);
      #5;
      for (int i = 0; i < 4; i++) rst_n[i] = 1'b1;
      @(negedge clk);

      fork
         begin
            for (int i = 0; i < 6; i++) begin
               send(vecs[i].id, vecs[i].data, vecs[i].e);
               vld_d[vecs[i].id] = 1'b0;
               wait_idle(vecs[i].id);
            end

            // Back-to-back with valid held high throughout.
            send(0, 8'h00, mk(10, 13'({1'b1, 8'h00, 1'b0})));
            send(0, 8'hFF, mk(10, 13'({1'b1, 8'hFF, 1'b0})));
            vld_d[0] = 1'b0;
            wait_idle(0);
            check("b2b_start_spacing", 32'(last_start[0] - prev_start[0]), 32'd4341);

            // Valid pulsed mid-frame and data churned must not disturb 0x55.
            seen0 = frames_seen[0];
            send(0, 8'h55, mk(10, 13'({1'b1, 8'h55, 1'b0})));
            vld_d[0] = 1'b0;
            repeat (1000) @(negedge clk);
            vld_d[0] = 1'b1;
            dat_d[0] = 8'h3C;
            @(negedge clk);
            vld_d[0] = 1'b0;
            check("ignored_valid_ready_low", 32'(rdy_w[0]), 32'd0);
            for (int k = 0; k < 2000; k++) begin
               @(negedge clk);
               dat_d[0] = 8'($urandom);
            end
            wait_idle(0);
            repeat (500) @(negedge clk);
            check("ignored_valid_frame_count", 32'(frames_seen[0] - seen0), 32'd1);
            check("ignored_valid_queue_empty", 32'(sb_size(0)), 32'd0);

            // Reset during data bit 3, then a byte offered on the first edge after release.
            send(0, 8'h00, mk(10, 13'({1'b1, 8'h00, 1'b0})));
            vld_d[0] = 1'b0;
            repeat (4 * 434 + 200) @(negedge clk);
            #5 rst_n[0] = 1'b0;
            #1 check("reset_async {tx,ready,busy}", 32'({tx_w[0], rdy_w[0], busy_w[0]}), 32'b110);
            @(negedge clk);
            @(negedge clk);
            dat_d[0] = 8'h81;
            vld_d[0] = 1'b1;
            sb_push(0, mk(10, 13'({1'b1, 8'h81, 1'b0})));
            #5 rst_n[0] = 1'b1;
            @(posedge clk);
            #1 check("first_edge_accept {tx,ready}", 32'({tx_w[0], rdy_w[0]}), 32'b00);
            @(negedge clk);
            vld_d[0] = 1'b0;
            wait_idle(0);
            check("reset_queue_drained", 32'(sb_size(0)), 32'd0);
         end
         begin
            for (int i = 0; i < 256; i++)
               send(3, 8'(i), mk(10, 13'({1'b1, 8'(i), 1'b0})));
            vld_d[3] = 1'b0;
            wait_idle(3);
            check("loopback_frame_count", 32'(frames_seen[3]), 32'd256);
            check("loopback_queue_empty", 32'(sb_size(3)), 32'd0);
         end
      join

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serialises parallel bytes into an asynchronous frame on a single TX line: 1 start bit, DATA_BITS data bits sent LSB first, an optional parity bit, and STOP_BITS stop bits. It is the transmit-side counterpart of the UART RX block and uses the same framing parameters, so a TX/RX pair with matching parameters forms a loopback link. Upstream logic hands bytes over with a valid/ready handshake; the block holds each byte internally until its frame has finished.

## Interface
Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate in bits/s.
- DATA_BITS, 8, data bits per frame; legal range is 5 to 9.
- STOP_BITS, 1, stop bits per frame; legal values are 1 or 2.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.

Ports:
- clk  input  1  system clock. One clock domain only.
- n_rst  input  1  reset. Asynchronous, active-low.
- i_data_valid  input  1  upstream presents a byte on i_data.
- i_data  input  DATA_BITS  byte to transmit.
- o_ready  output  1  high when the block can accept a byte. Reset value 1.
- o_tx  output  1  serial line, driven from a register. It idles high. Reset value 1.
- o_busy  output  1  high while a frame is in progress; equals ~o_ready. Reset value 0.

## Operation
- Bit period: CLKS_PER_BIT = int'(CLK_FREQ/BAUD_RATE + 0.5), which is the rounded value. Every bit on o_tx lasts exactly CLKS_PER_BIT cycles.
- Baud counter:
  - Width is $clog2(CLKS_PER_BIT+1).
  - It counts 0 to CLKS_PER_BIT-1 and wraps to 0 at the end of each bit.
  - It is held at 0 in IDLE.
- Bit counter: tracks the data index and the stop index, and is cleared on entry to each state.
- Shift register: DATA_BITS wide. It loads i_data on acceptance and shifts right at each data-bit boundary; o_tx takes bit 0.
- Parity bit:
  - Computed at acceptance from i_data and stored.
  - Odd mode: ~^i_data.
  - Even mode: ^i_data.
- FSM states are one-hot: IDLE, START, DATA, PARITY, STOP.
  - IDLE: o_tx=1, o_ready=1. On i_data_valid && o_ready, load the shift register and parity bit, then go to START.
  - START: o_tx=0 for one bit period, then go to DATA.
  - DATA: o_tx=shift[0] for DATA_BITS bit periods. Afterwards go to PARITY if PARITY!=0, otherwise go to STOP.
  - PARITY: o_tx=parity bit for one bit period, then go to STOP.
  - STOP: o_tx=1 for STOP_BITS bit periods, then go to IDLE.
- o_tx is registered and tracks the state and shift register with one cycle of latency.
- i_data_valid while o_ready=0 is ignored. The byte is not queued, and i_data may change freely during a frame without corrupting it.
- An unsupported PARITY value (3) behaves as no parity.

## Timing
- Acceptance happens at the clock edge where i_data_valid=1 and o_ready=1.
- o_ready falls on the next edge, together with o_tx falling to 0 for the start bit.
- Frame length: (1 + DATA_BITS + (PARITY?1:0) + STOP_BITS) × CLKS_PER_BIT cycles, measured from the first cycle o_tx=0 to the last stop-bit cycle inclusive.
- o_ready rises on the edge that ends the last stop bit.
- Minimum gap between frames:
  - The earliest next acceptance is that same cycle, with the start bit beginning one cycle later.
  - The line therefore stays high for exactly STOP_BITS × CLKS_PER_BIT + 1 cycles between frames when the next byte is valid continuously.
- Throughput: one byte per frame length + 1 cycle.
- Reset asserted mid-frame:
  - All outputs return immediately (asynchronously) to their reset values: o_tx=1, o_ready=1, o_busy=0.
  - The partial frame is abandoned.
  - After reset is released, the first byte is accepted on the first edge.

## Test plan
- Send 0xA5 (8N1) at 50 MHz / 115200 baud (CLKS_PER_BIT=434). Expected on o_tx: start 0, then 1,0,1,0,0,1,0,1, then stop 1. Each bit lasts 434 cycles, the frame is 4340 cycles, and o_ready is low throughout.
- Parity, DATA_BITS=8, on 0xA5:
  - PARITY=2 (even): parity bit is 0.
  - PARITY=1 (odd): parity bit is 1.
  - With STOP_BITS=2, the frame is 12 × 434 cycles.
- Back-to-back: hold i_data_valid=1 and send 0x00 then 0xFF. The second start bit begins exactly 434+1 cycles after the first frame's stop bit begins. Neither byte is dropped.
- Ignored valid: pulse i_data_valid with 0x3C mid-frame while sending 0x55. Only 0x55 appears on the line, and o_ready only rises after the stop bit.
- Reset mid-frame: assert n_rst low during data bit 3. o_tx=1, o_ready=1 and o_busy=0 immediately. After release, send 0x81 and check that a clean, complete frame is transmitted.
- Loopback with the UART RX block (matching parameters): send 256 sequential bytes. Every byte is received in order with a matching value and one o_data_valid pulse per frame.
